// File: rtl/micro_pkg.sv
// Shared definitions for the micro-CPU front end: sequencer state encoding
// and instruction-register field positions.
package micro_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2,
      S_EXEC   = 2'd3
   } seq_state_t;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 4;
   localparam int OPR_HI = 3;
   localparam int OPR_LO = 0;

endpackage

// File: rtl/pc_counter.sv
// Loadable program counter; wraps modulo 2^PC_W. Load has priority over increment.
module pc_counter #(
   parameter int PC_W     = 4,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_inc,
   input  logic            i_load,
   input  logic [PC_W-1:0] i_load_val,
   output logic [PC_W-1:0] o_pc
);

   logic [PC_W-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst)
         r_pc <= PC_W'(RESET_PC);
      else if (i_load)
         r_pc <= i_load_val;
      else if (i_inc)
         r_pc <= r_pc + 1'b1;
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Micro-CPU front end: fetch/decode/execute sequencer, IR, PC and condition flag.
// Optional SEQ_JUMP_EN adds a jump input that loads the PC from the operand at T2.
module instr_sequencer
   import micro_pkg::*;
#(
   parameter int PC_W     = 4,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            step,
   output logic [PC_W-1:0] mem_addr,
   input  logic [7:0]      mem_data,
   output logic [3:0]      opcode,
   output logic [3:0]      operand,
   output logic            T0,
   output logic            T1,
   output logic            T2,
   input  logic            flag_in,
   input  logic            flag_we,
`ifdef SEQ_JUMP_EN
   input  logic            jump,
`endif
   output logic            flag,
   output logic            busy,
   output logic            retire
);

   seq_state_t      r_state, w_state_nxt;
   logic            r_step_mode, w_step_mode_nxt;
   logic [7:0]      r_ir;
   logic            r_flag;
   logic            w_jump;
   logic            w_exec;
   logic [PC_W-1:0] w_pc;

`ifdef SEQ_JUMP_EN
   assign w_jump = jump;
`else
   assign w_jump = 1'b0;
`endif

   assign w_exec = (r_state == S_EXEC);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step_mode <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_step_mode <= w_step_mode_nxt;
      end
   end

   // run is only looked at in IDLE and EXEC, so an instruction always completes
   always_comb begin
      w_state_nxt     = r_state;
      w_step_mode_nxt = r_step_mode;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt     = S_FETCH;
               w_step_mode_nxt = 1'b0;
            end else if (step) begin
               w_state_nxt     = S_FETCH;
               w_step_mode_nxt = 1'b1;
            end
         end
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC: begin
            if (run && !r_step_mode) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt     = S_IDLE;
               w_step_mode_nxt = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir   <= 8'h00;
         r_flag <= 1'b0;
      end else begin
         if (r_state == S_FETCH)
            r_ir <= mem_data;
         if (w_exec && flag_we)
            r_flag <= flag_in;
      end
   end

   pc_counter #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_exec && !w_jump),
      .i_load     (w_exec && w_jump),
      .i_load_val (PC_W'(r_ir[OPR_HI:OPR_LO])),
      .o_pc       (w_pc)
   );

   assign mem_addr = w_pc;
   assign opcode   = r_ir[OPC_HI:OPC_LO];
   assign operand  = r_ir[OPR_HI:OPR_LO];
   assign T0       = (r_state == S_FETCH);
   assign T1       = (r_state == S_DECODE);
   assign T2       = w_exec;
   assign busy     = T0 | T1 | T2;
   assign retire   = w_exec;
   assign flag     = r_flag;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected retirements are queued as
// stimulus is set up and checked at each retire pulse.
module tb_instr_sequencer;

   localparam int PC_W = 4;

   typedef struct {
      logic [PC_W-1:0] addr;
      logic [3:0]      opc;
      logic [3:0]      opr;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            run = 1'b0;
   logic            step = 1'b0;
   logic [PC_W-1:0] mem_addr;
   logic [7:0]      mem_data;
   logic [3:0]      opcode, operand;
   logic            T0, T1, T2;
   logic            flag_in = 1'b0;
   logic            flag_we = 1'b0;
`ifdef SEQ_JUMP_EN
   logic            jump = 1'b0;
`endif
   logic            flag, busy, retire;

   logic [7:0] rom [16];
   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;

   assign mem_data = rom[mem_addr];

   always #5 clk = ~clk;

   instr_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .step     (step),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .opcode   (opcode),
      .operand  (operand),
      .T0       (T0),
      .T1       (T1),
      .T2       (T2),
      .flag_in  (flag_in),
      .flag_we  (flag_we),
`ifdef SEQ_JUMP_EN
      .jump     (jump),
`endif
      .flag     (flag),
      .busy     (busy),
      .retire   (retire)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom;
      for (int i = 0; i < 16; i++) rom[i] = 8'((i * 37) + 8'h11);
   endtask

   task automatic push_exp(input int a);
      exp_t e;
      e.addr = PC_W'(a);
      e.opc  = rom[a][7:4];
      e.opr  = rom[a][3:0];
      sb.push_back(e);
   endtask

   task automatic do_reset;
      run = 1'b0; step = 1'b0; flag_we = 1'b0; flag_in = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      sb.delete();
   endtask

   // Runs until n retires are seen; run is dropped at the nth T2.
   task automatic drain(input int n);
      int got = 0;
      int cyc = 0;
      int last = -1;
      exp_t e;
      while (got < n && cyc < 200) begin
         tick;
         cyc++;
         vectors++;
         if (busy !== (T0 | T1 | T2) || (32'(T0) + 32'(T1) + 32'(T2)) > 1 || retire !== T2) begin
            miscompares++;
            $display("FAIL strobes: T0T1T2=%b busy=%b retire=%b", {T0, T1, T2}, busy, retire);
         end
         if (retire) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_empty: unexpected retire at addr %0d", mem_addr);
            end else begin
               e = sb.pop_front();
               if ({mem_addr, opcode, operand} !== {e.addr, e.opc, e.opr}) begin
                  miscompares++;
                  $display("FAIL retire_data: got addr=%0d opc=%h opr=%h, want addr=%0d opc=%h opr=%h",
                           mem_addr, opcode, operand, e.addr, e.opc, e.opr);
               end
            end
            if (last >= 0) begin
               vectors++;
               if (cyc - last != 3) begin
                  miscompares++;
                  $display("FAIL t2_period: got %0d want 3", cyc - last);
               end
            end
            last = cyc;
            got++;
            if (got == n) run = 1'b0;
         end
      end
      if (got < n) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d retires want %0d", got, n);
      end
   endtask

   task automatic test_reset;
      fill_rom;
      rst = 1'b1;
      tick;
      tick;
      vectors++;
      if ({T0, T1, T2, busy, retire, flag, opcode, operand, mem_addr} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_state: T=%b busy=%b ret=%b flag=%b ir=%h%h addr=%0d want all 0",
                  {T0, T1, T2}, busy, retire, flag, opcode, operand, mem_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_run;
      do_reset;
      fill_rom;
      rom[0] = 8'h05; rom[1] = 8'h1A; rom[2] = 8'h2F;
      for (int i = 0; i < 3; i++) push_exp(i);
      run = 1'b1;
      tick;
      vectors++;
      if (T0 !== 1'b1 || mem_addr !== 4'd0) begin
         miscompares++;
         $display("FAIL run_first_fetch: T0=%b addr=%0d want T0=1 addr=0", T0, mem_addr);
      end
      drain(3);
      tick;
      vectors++;
      if (busy !== 1'b0 || mem_addr !== 4'd3) begin
         miscompares++;
         $display("FAIL run_stop: busy=%b addr=%0d want busy=0 addr=3", busy, mem_addr);
      end
   endtask

   task automatic test_step;
      exp_t e;
      do_reset;
      fill_rom;
      rom[0] = 8'h37;
      push_exp(0);
      step = 1'b1;
      tick;
      step = 1'b0;
      vectors++;
      if (T0 !== 1'b1 || mem_addr !== 4'd0) begin
         miscompares++;
         $display("FAIL step_fetch: T0=%b addr=%0d want T0=1 addr=0", T0, mem_addr);
      end
      tick;
      step = 1'b1;  // ignored: arrives during T1
      vectors++;
      if (T1 !== 1'b1 || opcode !== 4'h3 || operand !== 4'h7) begin
         miscompares++;
         $display("FAIL step_decode: T1=%b ir=%h%h want T1=1 ir=37", T1, opcode, operand);
      end
      tick;
      step = 1'b0;
      vectors++;
      if (retire !== 1'b1 || T2 !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL step_exec: retire=%b T2=%b want 1", retire, T2);
      end else begin
         e = sb.pop_front();
         vectors++;
         if ({mem_addr, opcode, operand} !== {e.addr, e.opc, e.opr}) begin
            miscompares++;
            $display("FAIL step_data: got %0d/%h%h want %0d/%h%h", mem_addr, opcode, operand, e.addr, e.opc, e.opr);
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         vectors++;
         if (busy !== 1'b0 || retire !== 1'b0 || mem_addr !== 4'd1 || opcode !== 4'h3) begin
            miscompares++;
            $display("FAIL step_idle: busy=%b retire=%b addr=%0d opc=%h want 0/0/1/3", busy, retire, mem_addr, opcode);
         end
      end
   endtask

   task automatic test_wrap;
      do_reset;
      fill_rom;
      for (int i = 0; i < 14; i++) push_exp(i);
      run = 1'b1;
      drain(14);
      tick;
      vectors++;
      if (busy !== 1'b0 || mem_addr !== 4'd14) begin
         miscompares++;
         $display("FAIL wrap_park: busy=%b addr=%0d want 0/14", busy, mem_addr);
      end
      push_exp(14); push_exp(15); push_exp(0); push_exp(1);
      run = 1'b1;
      drain(4);
      tick;
      vectors++;
      if (mem_addr !== 4'd2 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_end: addr=%0d left=%0d want addr=2 left=0", mem_addr, sb.size());
      end
   endtask

   task automatic test_flag;
      do_reset;
      fill_rom;
      run = 1'b1;
      tick; tick; tick;  // FETCH, DECODE, EXEC
      flag_we = 1'b1; flag_in = 1'b1;
      vectors++;
      if (T2 !== 1'b1 || flag !== 1'b0) begin
         miscompares++;
         $display("FAIL flag_pre: T2=%b flag=%b want 1/0", T2, flag);
      end
      tick;
      flag_we = 1'b0; flag_in = 1'b0;
      vectors++;
      if (flag !== 1'b1) begin
         miscompares++;
         $display("FAIL flag_set: got %b want 1", flag);
      end
      tick; tick;
      run = 1'b0;
      tick;
      vectors++;
      if (flag !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flag_hold: flag=%b busy=%b want 1/0", flag, busy);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      vectors++;
      if (flag !== 1'b0) begin
         miscompares++;
         $display("FAIL flag_rst: got %b want 0", flag);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      fill_rom;
      step = 1'b1; tick; step = 1'b0;
      tick; tick; tick;  // PC now 1
      run = 1'b1;
      tick; tick;
      vectors++;
      if (T1 !== 1'b1 || mem_addr !== 4'd1) begin
         miscompares++;
         $display("FAIL mid_setup: T1=%b addr=%0d want 1/1", T1, mem_addr);
      end
      rst = 1'b1;
      tick;
      vectors++;
      if ({T0, T1, T2, busy, retire, opcode, operand, mem_addr} !== 16'h0) begin
         miscompares++;
         $display("FAIL mid_reset: T=%b busy=%b ret=%b ir=%h%h addr=%0d want all 0",
                  {T0, T1, T2}, busy, retire, opcode, operand, mem_addr);
      end
      tick;
      rst = 1'b0;
      vectors++;
      if (busy !== 1'b0 || retire !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_hold: busy=%b retire=%b want 0/0", busy, retire);
      end
      tick;
      run = 1'b0;
      vectors++;
      if (T0 !== 1'b1 || mem_addr !== 4'd0) begin
         miscompares++;
         $display("FAIL mid_restart: T0=%b addr=%0d want 1/0", T0, mem_addr);
      end
      tick; tick; tick;
   endtask

   task automatic test_jump;
      exp_t e;
      do_reset;
      fill_rom;
      rom[3] = 8'h49;
      for (int i = 0; i < 3; i++) push_exp(i);
      run = 1'b1;
      drain(3);
      tick;
      push_exp(3);
      step = 1'b1; tick; step = 1'b0;
      tick; tick;
`ifdef SEQ_JUMP_EN
      jump = 1'b1;
`endif
      vectors++;
      if (retire !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL jump_exec: retire=%b want 1", retire);
      end else begin
         e = sb.pop_front();
         if ({mem_addr, opcode, operand} !== {e.addr, e.opc, e.opr}) begin
            miscompares++;
            $display("FAIL jump_data: got %0d/%h%h want %0d/%h%h", mem_addr, opcode, operand, e.addr, e.opc, e.opr);
         end
      end
      tick;
`ifdef SEQ_JUMP_EN
      jump = 1'b0;
      vectors++;
      if (mem_addr !== 4'd9) begin
         miscompares++;
         $display("FAIL jump_target: got %0d want 9", mem_addr);
      end
`else
      vectors++;
      if (mem_addr !== 4'd4) begin
         miscompares++;
         $display("FAIL jump_target: got %0d want 4", mem_addr);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_run;
      test_step;
      test_wrap;
      test_flag;
      test_reset_mid;
      test_jump;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Front end of the micro-CPU. Drives the opcode decoder: it fetches 8-bit instructions from the program ROM, holds them in an instruction register, and generates the T0/T1/T2 phase strobes.
- Owns the program counter and the condition flag that the decoder consumes.
- Supports free-run and single-step operation from the top-level controls.

Parameters:
PC_W, 4, program counter / ROM address width (program length 2^PC_W)
RESET_PC, 0, PC value loaded by reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  level; high = execute continuously
step  in  1  single-cycle pulse; executes one instruction while not running
mem_addr  out  PC_W  ROM address (= PC)
mem_data  in  8  ROM data, combinational from mem_addr; [7:4] opcode, [3:0] operand
opcode  out  4  IR[7:4], to decoder
operand  out  4  IR[3:0], immediate to datapath
T0  out  1  fetch phase strobe
T1  out  1  decode phase strobe
T2  out  1  execute phase strobe (register enables gated with this)
flag_in  in  1  condition result from ALU/accumulator
flag_we  in  1  capture flag_in at end of T2
flag  out  1  registered condition flag, to decoder
busy  out  1  high while an instruction is in progress (T0|T1|T2)
retire  out  1  one-cycle pulse, coincident with T2

Behaviour:
- State machine: IDLE, FETCH, DECODE, EXEC. T0/T1/T2 are one-hot decodes of FETCH/DECODE/EXEC; all low in IDLE.
- Reset (synchronous, has priority over everything):
  - state=IDLE, PC=RESET_PC, IR=8'h00, flag=0.
  - All outputs low except mem_addr=RESET_PC.
  - Reset mid-instruction abandons the instruction: no T2 is issued and the PC does not advance.
- IDLE:
  - run=1 -> FETCH.
  - Else step=1 -> FETCH with step_mode latched.
  - Else stay.
  - run and step both high: run wins, step_mode is cleared.
- FETCH (T0=1): mem_addr=PC, stable for the whole cycle. IR <= mem_data at the end of the cycle. -> DECODE.
- DECODE (T1=1): IR stable on opcode/operand; the decoder settles. -> EXEC.
- EXEC (T2=1, retire=1):
  - PC <= PC+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0.
  - If flag_we=1, flag <= flag_in.
  - Next state: FETCH if run=1 and step_mode=0; otherwise IDLE, and step_mode is cleared.
- run is sampled only in IDLE and EXEC. Dropping run during FETCH/DECODE completes the current instruction, then stops in IDLE.
- step pulses arriving while busy=1 are ignored; they are not queued.
- Latency:
  - Run mode: 3 clk per instruction; T2 of consecutive instructions is 3 cycles apart.
  - From IDLE: T0 is asserted 1 cycle after run/step is sampled high.
- flag holds its value across IDLE and stepping; it is changed only by flag_we at T2 or by rst.
- opcode/operand hold the last fetched instruction while IDLE. The decoder's non-T2-gated outputs may therefore remain active; datapath enables are safe because T2=0.

Optional Feature:
- Macro SEQ_JUMP_EN.
- When defined:
  - Adds input jump (1 bit).
  - In EXEC with jump=1: PC <= {zero-extended operand} instead of PC+1. For PC_W>4 the upper bits are cleared.
  - jump and flag_we may be asserted together; both take effect.
- When undefined:
  - No jump port.
  - The PC always increments in EXEC.

Decomposition:
- Shared package micro_pkg:
  - State encoding constants S_IDLE, S_FETCH, S_DECODE, S_EXEC (2 bits).
  - Field positions OPC_HI=7, OPC_LO=4, OPR_HI=3, OPR_LO=0.
- Optional sub-module pc_counter: loadable, wrapping PC_W counter with inc/load/reset. Everything else stays flat in instr_sequencer.

Test Plan:
- Reset then run=1, ROM[0..2]=8'h05,8'h1A,8'h2F -> T0,T1,T2 rotate with period 3. opcode=0,1,2 and operand=5,A,F at each T2. mem_addr=0,1,2.
- step pulse from IDLE with ROM[0]=8'h37 -> exactly one T0,T1,T2 (one retire), then IDLE. PC=1, opcode=3 retained, busy=0. A second step pulse during T1 is ignored.
- PC_W=4, run from PC=14 -> executes addresses 14, 15, 0, 1; mem_addr wraps 15->0 with no gap in strobes.
- flag_we=1, flag_in=1 at a T2 -> flag=1 from the next cycle. flag_we=0 with flag_in=0 at the following T2 -> flag stays 1. rst -> flag=0.
- rst asserted during DECODE -> next cycle: IDLE, T0/T1/T2=0, PC=RESET_PC, IR=0. No retire pulse. run=1 held through rst -> fetch from address 0 starts 1 cycle after rst drops.
- SEQ_JUMP_EN defined, ROM[3]=8'h49, jump=1 at its T2 -> next mem_addr=9. Without the macro, the same stimulus gives mem_addr=4.
